// File: rtl/mul_exu.sv
// mul_exu: single-issue multiply/divide execution unit that broadcasts its result over the CDB.
// Build option: define MUL_EXU_DIV_EN to include the restoring divider for opcodes 4..7.
module mul_exu #(
    parameter int unsigned  TAG_W     = 4,
    parameter int unsigned  OPC_W     = 4,
    parameter int unsigned  ROB_DEPTH = 16,
    parameter int unsigned  MUL_LAT   = 2,
    localparam int unsigned ROB_PTR_W = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exu_req,
    output logic                 exu_rdy,
    input  logic [TAG_W-1:0]     exu_tag,
    input  logic [OPC_W-1:0]     exu_opc,
    input  logic [31:0]          exu_src1,
    input  logic [31:0]          exu_src2,
    input  logic [ROB_PTR_W-1:0] exu_inst_id,
    output logic                 cdb_req,
    input  logic                 cdb_gnt,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [31:0]          cdb_wdata,
    output logic [ROB_PTR_W-1:0] cdb_inst_id
);

    localparam int unsigned CNT_W   = 6;
    // One operand-setup cycle, 32 iterations, one sign-fixup cycle.
    localparam int unsigned DIV_CYC = 34;

    typedef enum logic [1:0] { IDLE, MUL, DIV, DONE } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_accept;
    logic                  w_is_div_op;

    logic                  r_rdy;
    logic                  r_cdb_req;
    logic [TAG_W-1:0]      r_tag;
    logic [OPC_W-1:0]      r_opc;
    logic [31:0]           r_src1;
    logic [31:0]           r_src2;
    logic [ROB_PTR_W-1:0]  r_inst_id;
    logic [31:0]           r_wdata;
    logic [31:0]           w_mul_res;
    logic [31:0]           w_div_res;

    logic                  w_a_sgn;
    logic                  w_b_sgn;
    logic [63:0]           w_a_ext;
    logic [63:0]           w_b_ext;
    logic [63:0]           w_prod;

    assign exu_rdy     = r_rdy;
    assign cdb_req     = r_cdb_req;
    assign cdb_tag     = r_tag;
    assign cdb_wdata   = r_wdata;
    assign cdb_inst_id = r_inst_id;

    // State and latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (exu_req) begin
                    w_accept = 1'b1;
                    if (w_is_div_op) begin
                        w_state_nxt = DIV;
                        w_cnt_nxt   = CNT_W'(DIV_CYC - 1);
                    end else begin
                        w_state_nxt = MUL;
                        w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
                    end
                end
            end
            MUL, DIV: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (r_cdb_req && cdb_gnt) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture and registered CDB payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy     <= 1'b1;
            r_cdb_req <= 1'b0;
            r_tag     <= '0;
            r_opc     <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_inst_id <= '0;
            r_wdata   <= '0;
        end else begin
            r_rdy     <= (w_state_nxt == IDLE);
            r_cdb_req <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_tag     <= exu_tag;
                r_opc     <= exu_opc;
                r_src1    <= exu_src1;
                r_src2    <= exu_src2;
                r_inst_id <= exu_inst_id;
            end
            if ((r_state == MUL) && (r_cnt == '0)) begin
                r_wdata <= w_mul_res;
            end
            if ((r_state == DIV) && (r_cnt == '0)) begin
                r_wdata <= w_div_res;
            end
        end
    end

    // 33-bit sign/zero extension per opcode; low 64 bits of the product are exact.
    assign w_a_sgn = ((r_opc == OPC_W'(1)) || (r_opc == OPC_W'(2))) && r_src1[31];
    assign w_b_sgn = (r_opc == OPC_W'(1)) && r_src2[31];
    assign w_a_ext = {{32{w_a_sgn}}, r_src1};
    assign w_b_ext = {{32{w_b_sgn}}, r_src2};
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
        w_mul_res = '0;
        if (r_opc == OPC_W'(0)) begin
            w_mul_res = w_prod[31:0];
        end else if (r_opc <= OPC_W'(3)) begin
            w_mul_res = w_prod[63:32];
        end
    end

`ifdef MUL_EXU_DIV_EN
    logic        w_signed;
    logic        w_neg1;
    logic        w_neg2;
    logic        w_ge;
    logic [32:0] w_rem_sh;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo;
    logic [31:0] w_rmd;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;

    assign w_is_div_op = (exu_opc >= OPC_W'(4)) && (exu_opc <= OPC_W'(7));
    assign w_signed    = ~r_opc[0];
    assign w_neg1      = w_signed & r_src1[31];
    assign w_neg2      = w_signed & r_src2[31];

    assign w_rem_sh  = {r_rem, r_dvd[31]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? 32'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[31:0];

    // Restoring divider on magnitudes; r_dvd shifts out dividend bits and in quotient bits.
    always_ff @(posedge clk) begin
        if (r_state == DIV) begin
            if (r_cnt == CNT_W'(DIV_CYC - 1)) begin
                r_dvd <= w_neg1 ? (~r_src1 + 32'd1) : r_src1;
                r_dvs <= w_neg2 ? (~r_src2 + 32'd1) : r_src2;
                r_rem <= '0;
            end else if (r_cnt != '0) begin
                r_rem <= w_rem_nxt;
                r_dvd <= {r_dvd[30:0], w_ge};
            end
        end
    end

    // Zero divisor forces an all-ones quotient; the remainder already equals the dividend.
    assign w_quo     = (r_src2 == '0) ? '1
                     : ((w_neg1 ^ w_neg2) ? (~r_dvd + 32'd1) : r_dvd);
    assign w_rmd     = w_neg1 ? (~r_rem + 32'd1) : r_rem;
    assign w_div_res = r_opc[1] ? w_rmd : w_quo;
`else
    assign w_is_div_op = 1'b0;
    assign w_div_res   = '0;
`endif

endmodule

// File: tb/tb_mul_exu.sv
// tb_mul_exu: directed and randomized checks of mul_exu against an arithmetic reference model.
module tb_mul_exu;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_req;
    logic        exu_rdy;
    logic [3:0]  exu_tag;
    logic [3:0]  exu_opc;
    logic [31:0] exu_src1;
    logic [31:0] exu_src2;
    logic [3:0]  exu_inst_id;
    logic        cdb_req;
    logic        cdb_gnt;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_wdata;
    logic [3:0]  cdb_inst_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_exu #(
        .TAG_W     (4),
        .OPC_W     (4),
        .ROB_DEPTH (16),
        .MUL_LAT   (MUL_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exu_req     (exu_req),
        .exu_rdy     (exu_rdy),
        .exu_tag     (exu_tag),
        .exu_opc     (exu_opc),
        .exu_src1    (exu_src1),
        .exu_src2    (exu_src2),
        .exu_inst_id (exu_inst_id),
        .cdb_req     (cdb_req),
        .cdb_gnt     (cdb_gnt),
        .cdb_tag     (cdb_tag),
        .cdb_wdata   (cdb_wdata),
        .cdb_inst_id (cdb_inst_id)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    function automatic bit div_op(input logic [3:0] opc);
`ifdef MUL_EXU_DIV_EN
        return (opc >= 4'd4) && (opc <= 4'd7);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_lat(input logic [3:0] opc);
        return div_op(opc) ? int'(DIV_LAT) : int'(MUL_LAT);
    endfunction

    // Reference result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [3:0] opc, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (opc)
            4'd0: begin p = 64'(ua * ub); return p[31:0];  end
            4'd1: begin p = 64'(sa * sb); return p[63:32]; end
            4'd2: begin p = 64'(sa * ub); return p[63:32]; end
            4'd3: begin p = 64'(ua * ub); return p[63:32]; end
            default: ;
        endcase
        if (!div_op(opc)) return 32'd0;
        if (b == 32'd0) return (opc <= 4'd5) ? 32'hFFFF_FFFF : a;
        if (opc == 4'd4) return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
        if (opc == 4'd5) return 32'(ua / ub);
        if (opc == 4'd6) return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
        return 32'(ua % ub);
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, check latency and payload, optionally stall the grant, then release.
    task automatic run_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [3:0] id, input int gnt_dly);
        logic [31:0] exp;
        int          n;
        exp = ref_res(opc, a, b);
        n = 0;
        while (!exu_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("rdy_idle", exu_rdy, 1'b1);
        exu_req     = 1'b1;
        exu_opc     = opc;
        exu_src1    = a;
        exu_src2    = b;
        exu_tag     = tag;
        exu_inst_id = id;
        cdb_gnt     = (gnt_dly == 0);
        @(negedge clk);
        exu_req     = 1'b0;
        exu_opc     = 4'($urandom);
        exu_src1    = $urandom;
        exu_src2    = $urandom;
        exu_tag     = 4'($urandom);
        exu_inst_id = 4'($urandom);
        n = 0;
        while (!cdb_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(ref_lat(opc)));
        chk("wdata", cdb_wdata, exp);
        chk("tag", 32'(cdb_tag), 32'(tag));
        chk("inst_id", 32'(cdb_inst_id), 32'(id));
        chk1("rdy_done", exu_rdy, 1'b0);
        if (gnt_dly > 0) begin
            exu_req = 1'b1;
            repeat (gnt_dly) begin
                @(negedge clk);
                chk1("hold_req", cdb_req, 1'b1);
                chk1("hold_rdy", exu_rdy, 1'b0);
                chk("hold_wdata", cdb_wdata, exp);
                chk("hold_tag", 32'(cdb_tag), 32'(tag));
                chk("hold_id", 32'(cdb_inst_id), 32'(id));
            end
            exu_req = 1'b0;
            cdb_gnt = 1'b1;
        end
        @(negedge clk);
        cdb_gnt = 1'b0;
        chk1("req_drop", cdb_req, 1'b0);
        chk1("rdy_after", exu_rdy, 1'b1);
    endtask

    // Start an op and reset dly cycles after accept (dly 0: reset together with the request).
    task automatic abort_op(input logic [3:0] opc, input int dly);
        int seen;
        exu_req     = 1'b1;
        exu_opc     = opc;
        exu_src1    = $urandom;
        exu_src2    = $urandom | 32'd1;
        exu_tag     = 4'hA;
        exu_inst_id = 4'h7;
        cdb_gnt     = 1'b0;
        rst         = (dly == 0);
        @(negedge clk);
        exu_req = 1'b0;
        if (dly > 0) begin
            repeat (dly - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        chk1("abort_req", cdb_req, 1'b0);
        chk("abort_wdata", cdb_wdata, 32'd0);
        chk("abort_tag", 32'(cdb_tag), 32'd0);
        chk("abort_id", 32'(cdb_inst_id), 32'd0);
        chk1("abort_rdy", exu_rdy, 1'b1);
        cdb_gnt = 1'b1;
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (cdb_req) seen++;
        end
        cdb_gnt = 1'b0;
        chk("abort_no_bcast", 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        exu_req     = 1'b0;
        cdb_gnt     = 1'b0;
        exu_tag     = '0;
        exu_opc     = '0;
        exu_src1    = '0;
        exu_src2    = '0;
        exu_inst_id = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk1("rst_req", cdb_req, 1'b0);
        chk("rst_wdata", cdb_wdata, 32'd0);
        chk("rst_tag", 32'(cdb_tag), 32'd0);
        chk("rst_id", 32'(cdb_inst_id), 32'd0);
        chk1("rst_rdy", exu_rdy, 1'b1);

        run_op(4'd0, 32'd7, 32'd6, 4'd3, 4'd5, 0);
        chk("mul_7x6", cdb_wdata, 32'd42);
        run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 4'd1, 0);
        run_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 4'd2, 1);
        chk("mulhu_ones", cdb_wdata, 32'hFFFF_FFFE);
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 4'd4, 4'd3, 0);
        chk("mulhsu_m1x2", cdb_wdata, 32'hFFFF_FFFF);
        run_op(4'd0, 32'd1234, 32'd5678, 4'd9, 4'd11, 10);
        run_op(4'd12, 32'd5, 32'd6, 4'd6, 4'd6, 0);

`ifdef MUL_EXU_DIV_EN
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 4'd1, 4'd2, 0);
        chk("div_m7_2", cdb_wdata, 32'hFFFF_FFFD);
        run_op(4'd6, 32'hFFFF_FFF9, 32'd2, 4'd1, 4'd2, 0);
        chk("rem_m7_2", cdb_wdata, 32'hFFFF_FFFF);
        run_op(4'd5, 32'd100, 32'd0, 4'd3, 4'd3, 2);
        run_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 4'd4, 0);
        chk("div_ovf", cdb_wdata, 32'h8000_0000);
        run_op(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd5, 4'd5, 0);
        run_op(4'd6, 32'hFFFF_FFF0, 32'd0, 4'd6, 4'd6, 0);
        run_op(4'd4, 32'hFFFF_FFF0, 32'd0, 4'd7, 4'd7, 0);
        abort_op(4'd4, 5);
`else
        run_op(4'd4, 32'd10, 32'd2, 4'd1, 4'd2, 0);
        chk("nodiv_zero", cdb_wdata, 32'd0);
        abort_op(4'd0, 1);
`endif
        run_op(4'd0, 32'd3, 32'd3, 4'd8, 4'd9, 0);
        chk("mul_3x3", cdb_wdata, 32'd9);
        abort_op(4'd1, 0);
        abort_op(4'd0, 3);
        run_op(4'd3, 32'h1234_5678, 32'h9ABC_DEF0, 4'd2, 4'd1, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(),
                   4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_exu.md
MUL_EXU -- requirements
Module: mul_exu

Interface
REQ-001 SHALL have parameter TAG_W, default 4, tag width shared with reservation stations and the CDB.
REQ-002 SHALL have parameter OPC_W, default 4, opcode width.
REQ-003 SHALL have parameter ROB_DEPTH, default 16, ROB entry count; ROB_PTR_W = clog2(ROB_DEPTH).
REQ-004 SHALL have parameter MUL_LAT, default 2, multiply cycles from accept to result ready; legal range 1..8.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 exu_req  in  1  reservation station has a ready instruction.
REQ-008 exu_rdy  out  1  unit can accept this cycle.
REQ-009 exu_tag  in  TAG_W  tag of issuing reservation station entry.
REQ-010 exu_opc  in  OPC_W  operation code.
REQ-011 exu_src1 / exu_src2  in  32 each  operands rs1 / rs2.
REQ-012 exu_inst_id  in  ROB_PTR_W  ROB index of the instruction.
REQ-013 cdb_req  out  1  result pending broadcast.
REQ-014 cdb_gnt  in  1  CDB arbiter grant; broadcast completes in a cycle where cdb_req and cdb_gnt are both high.
REQ-015 cdb_tag / cdb_wdata / cdb_inst_id  out  TAG_W / 32 / ROB_PTR_W  broadcast payload.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-017 exu_rdy SHALL be 1 only in IDLE; accept = exu_req && exu_rdy.
REQ-018 On accept, SHALL capture tag, opc, src1, src2 and inst_id into internal registers; inputs are not sampled again until the next accept.
REQ-019 Opcodes: 0 MUL (low 32), 1 MULH (s x s, high), 2 MULHSU (s x u, high), 3 MULHU (u x u, high), 4 DIV, 5 DIVU, 6 REM, 7 REMU; 8..15 undefined.
REQ-020 Accept with opc 0..3 or 8..15 SHALL enter MUL; a down-counter loaded with MUL_LAT-1 decrements each cycle; MUL->DONE when the counter is 0.
REQ-021 Multiply SHALL form a 64-bit product from 33-bit sign/zero-extended operands per opcode; undefined opcodes SHALL produce result 0.
REQ-022 DIV SHALL be a restoring radix-2 divider on operand magnitudes: exactly 32 iteration cycles, then 1 sign-fixup cycle, then DONE (accept-to-cdb_req = 34 cycles).
REQ-023 Divide by zero: DIV/DIVU quotient 0xFFFFFFFF, REM/REMU remainder = src1; SHALL still take the full 34 cycles.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV quotient 0x80000000, REM remainder 0.
REQ-025 Remainder sign SHALL follow dividend; quotient sign SHALL be XOR of operand signs (signed ops only).
REQ-026 In DONE, cdb_req SHALL be 1 and payload SHALL be stable until grant; on cdb_req && cdb_gnt, next state IDLE and cdb_req 0 next cycle.
REQ-027 cdb_gnt while not in DONE SHALL be ignored.
REQ-028 Minimum back-to-back issue interval SHALL be MUL_LAT+2 cycles for multiplies (accept, MUL_LAT cycles, DONE with grant, IDLE).
REQ-029 cdb_tag SHALL equal the captured exu_tag; cdb_inst_id SHALL equal the captured exu_inst_id.

Reset
REQ-030 rst SHALL force IDLE, counter 0, cdb_req 0, cdb_tag 0, cdb_wdata 0, cdb_inst_id 0; exu_rdy reads 1 in the cycle after rst deasserts.
REQ-031 rst asserted in MUL, DIV or DONE SHALL discard the operation; no broadcast of it follows.
REQ-032 rst SHALL take priority over accept and grant in the same cycle.

Configuration
REQ-033 Macro MUL_EXU_DIV_EN: when defined, the divider and the DIV state are built and REQ-022..025 apply.
REQ-034 Without MUL_EXU_DIV_EN: no divider logic; opcodes 4..7 take the MUL path with MUL_LAT latency and result 0; the DIV state is never entered.

Verification
REQ-035 MUL_LAT=2, opc 0, src1 7, src2 6, tag 3, inst_id 5, cdb_gnt=1 -> cdb_req 2 cycles after accept, wdata 42, tag 3, inst_id 5; exu_rdy 1 the cycle after.
REQ-036 opc 1, src1 0xFFFFFFFF, src2 0xFFFFFFFF -> wdata 0; opc 3 same operands -> wdata 0xFFFFFFFE; opc 2 src1 0xFFFFFFFF, src2 2 -> wdata 0xFFFFFFFF.
REQ-037 DIV_EN, opc 4, src1 -7, src2 2 -> 34 cycles later wdata 0xFFFFFFFD; opc 6 same operands -> 0xFFFFFFFF; opc 5 src2 0 -> 0xFFFFFFFF; opc 4 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-038 Hold cdb_gnt=0 for 10 cycles in DONE -> cdb_req and payload unchanged, exu_rdy 0, new exu_req not accepted; raise gnt -> one broadcast, IDLE next cycle.
REQ-039 Assert rst 5 cycles into a DIV -> cdb_req never rises for it; exu_rdy 1 after reset; next MUL 3x3 broadcasts 9.
REQ-040 Without DIV_EN, opc 4 src1 10 src2 2 -> wdata 0 after MUL_LAT cycles.
